pfd_loop_controller: RTL and testbench

//  Digital back end of the ADPLL phase frequency detector. Measures the asynchronous UP/DN

---
 rtl/pfd_adpll_pkg.sv | 27 ++
 rtl/pfd_sync2.sv | 22 ++
 rtl/pfd_loop_controller.sv | 158 +++++++++++++++
 tb/tb_pfd_loop_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pfd_adpll_pkg.sv
// Shared types, default parameters and helpers for the ADPLL PFD back end.
package pfd_adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_UPDATE  = 2'd2,
    ST_STUCK   = 2'd3
  } pfd_state_t;

  localparam int DEF_CW        = 8;
  localparam int DEF_CNT_W     = 6;
  localparam int DEF_KP_SH     = 1;
  localparam int DEF_KI_SH     = 3;
  localparam int DEF_INIT_CODE = 128;
  localparam int DEF_LOCK_TOL  = 1;
  localparam int DEF_LOCK_N    = 8;
  localparam int DEF_TIMEOUT   = 63;

  // Saturate v into [lo, hi]; used so the integrator and DCO code never wrap.
  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pfd_sync2.sv
// Two-flop synchroniser for the asynchronous PFD pulses.
module pfd_sync2 (
  input  logic clk,
  input  logic reset_b,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the pin through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pfd_loop_controller.sv
// ADPLL PFD back end: measures UP/DN pulse widths per window and runs a
// PI loop filter on the difference to produce the DCO code and lock flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a synced UP/DN pulse; counters held clear
// MEASURE | counting UP/DN/window cycles until both pulses are low
// UPDATE  | one cycle: integrate error, compute DCO code, evaluate lock
// STUCK   | window timed out; wait for both pulses low before re-arming
module pfd_loop_controller
  import pfd_adpll_pkg::*;
#(
  parameter int CW        = DEF_CW,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int KP_SH     = DEF_KP_SH,
  parameter int KI_SH     = DEF_KI_SH,
  parameter int INIT_CODE = DEF_INIT_CODE,
  parameter int LOCK_TOL  = DEF_LOCK_TOL,
  parameter int LOCK_N    = DEF_LOCK_N,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            up,
  input  logic            dn,
  input  logic            en,
  output logic [CW-1:0]   dco_code,
  output logic            code_vld,
  output logic [CNT_W:0]  err,
  output logic            lock
);

  localparam int ACC_W    = CW + KI_SH;
  localparam int ACC_MAX  = (1 << ACC_W) - 1;
  localparam int CODE_MAX = (1 << CW) - 1;
  localparam int LOCK_W   = $clog2(LOCK_N + 1);

  logic                  up_s;
  logic                  dn_s;
  logic                  any_s;
  pfd_state_t            state;
  logic [CNT_W-1:0]      up_cnt;
  logic [CNT_W-1:0]      dn_cnt;
  logic [CNT_W-1:0]      win_cnt;
  logic                  timeout_flag;
  logic [ACC_W-1:0]      acc;
  logic [LOCK_W-1:0]     lock_cnt;

  logic [CNT_W-1:0]      up_inc;
  logic [CNT_W-1:0]      dn_inc;
  logic [CNT_W-1:0]      win_inc;
  logic signed [CNT_W:0] err_c;
  int                    err_i;
  logic [ACC_W-1:0]      acc_nxt;
  logic [CW-1:0]         code_nxt;
  logic                  in_lock;
  logic [LOCK_W-1:0]     lock_cnt_nxt;

  pfd_sync2 u_sync_up (.clk(clk), .reset_b(reset_b), .d(up), .q(up_s));
  pfd_sync2 u_sync_dn (.clk(clk), .reset_b(reset_b), .d(dn), .q(dn_s));

  assign any_s = up_s | dn_s;

  // Saturating increments for the window counters.
  always_comb begin
    up_inc  = (up_s && !(&up_cnt)) ? up_cnt + CNT_W'(1) : up_cnt;
    dn_inc  = (dn_s && !(&dn_cnt)) ? dn_cnt + CNT_W'(1) : dn_cnt;
    win_inc = (&win_cnt) ? win_cnt : win_cnt + CNT_W'(1);
  end

  // PI filter and lock qualification for the window just measured.
  always_comb begin
    err_c    = $signed({1'b0, up_cnt}) - $signed({1'b0, dn_cnt});
    err_i    = int'(err_c);
    acc_nxt  = ACC_W'(clamp(int'(acc) + err_i, 0, ACC_MAX));
    code_nxt = CW'(clamp(int'(acc_nxt >> KI_SH) + err_i * (2 ** KP_SH), 0, CODE_MAX));
    in_lock  = (err_i <= LOCK_TOL) && (err_i >= -LOCK_TOL);
    if (!in_lock) begin
      lock_cnt_nxt = '0;
    end else if (lock_cnt == LOCK_W'(LOCK_N)) begin
      lock_cnt_nxt = lock_cnt;
    end else begin
      lock_cnt_nxt = lock_cnt + LOCK_W'(1);
    end
  end

  // Window FSM with the filter state and registered outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= ST_IDLE;
      up_cnt       <= '0;
      dn_cnt       <= '0;
      win_cnt      <= '0;
      timeout_flag <= 1'b0;
      acc          <= ACC_W'(INIT_CODE * (2 ** KI_SH));
      lock_cnt     <= '0;
      dco_code     <= CW'(INIT_CODE);
      code_vld     <= 1'b0;
      err          <= '0;
      lock         <= 1'b0;
    end else begin
      code_vld <= 1'b0;
      if (!en) begin
        // Frozen loop: drop the window and lock history, keep the code.
        state        <= ST_IDLE;
        up_cnt       <= '0;
        dn_cnt       <= '0;
        win_cnt      <= '0;
        timeout_flag <= 1'b0;
        lock_cnt     <= '0;
        lock         <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            timeout_flag <= 1'b0;
            if (any_s) begin
              // The first high sample already belongs to the window.
              up_cnt  <= CNT_W'(up_s);
              dn_cnt  <= CNT_W'(dn_s);
              win_cnt <= CNT_W'(1);
              state   <= ST_MEASURE;
            end else begin
              up_cnt  <= '0;
              dn_cnt  <= '0;
              win_cnt <= '0;
            end
          end
          ST_MEASURE: begin
            up_cnt  <= up_inc;
            dn_cnt  <= dn_inc;
            win_cnt <= win_inc;
            if (!any_s) begin
              state <= ST_UPDATE;
            end else if (win_cnt == CNT_W'(TIMEOUT - 1)) begin
              timeout_flag <= 1'b1;
              state        <= ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            acc          <= acc_nxt;
            dco_code     <= code_nxt;
            err          <= err_c;
            code_vld     <= 1'b1;
            lock_cnt     <= lock_cnt_nxt;
            lock         <= (lock_cnt_nxt == LOCK_W'(LOCK_N));
            timeout_flag <= 1'b0;
            state        <= timeout_flag ? ST_STUCK : ST_IDLE;
          end
          ST_STUCK: begin
            if (!any_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pfd_loop_controller.sv
// Directed bench for pfd_loop_controller: table of pulse windows with
// hand-computed filter results, plus timeout, enable and reset sequences.
module tb_pfd_loop_controller;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       up;
  logic       dn;
  logic       en;
  logic [7:0] dco_code;
  logic       code_vld;
  logic [6:0] err;
  logic       lock;

  int total = 0;
  int bad   = 0;
  int cap_err, cap_dco, cap_lock, cap_lat;

  typedef struct {
    int up_len;
    int dn_len;
    int up_off;
    int dn_off;
    int exp_err;
    int exp_dco;
    int exp_lock;
  } vec_t;

  vec_t vecs[22];

  always #2 clk = ~clk;

  pfd_loop_controller dut (
    .clk(clk), .reset_b(reset_b), .up(up), .dn(dn), .en(en),
    .dco_code(dco_code), .code_vld(code_vld), .err(err), .lock(lock)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Watch n falling edges, count strobes and capture outputs at the last one.
  task automatic count_vld(input int n, output int c);
    c = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (code_vld) begin
        c++;
        cap_err  = int'($signed(err));
        cap_dco  = int'(dco_code);
        cap_lock = int'(lock);
        cap_lat  = k;
      end
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   len;
    int   c;
    v   = vecs[i];
    len = v.up_off + v.up_len;
    if (v.dn_off + v.dn_len > len) len = v.dn_off + v.dn_len;
    for (int k = 0; k < len; k++) begin
      up = (k >= v.up_off) && (k < v.up_off + v.up_len);
      dn = (k >= v.dn_off) && (k < v.dn_off + v.dn_len);
      @(negedge clk);
    end
    up = 1'b0;
    dn = 1'b0;
    count_vld(12, c);
    check($sformatf("v%0d strobes", i), c, 1);
    check($sformatf("v%0d latency", i), cap_lat, 4);
    check($sformatf("v%0d err", i), cap_err, v.exp_err);
    check($sformatf("v%0d dco", i), cap_dco, v.exp_dco);
    check($sformatf("v%0d lock", i), cap_lock, v.exp_lock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c, c2, c3;

    // acc starts at 1024 (128<<3); code = clamp((acc>>3) + 2*err)
    vecs[0] = '{5, 1, 0, 4, 4, 136, 0};            // acc 1028
    for (int i = 1; i <= 8; i++)
      vecs[i] = '{3, 3, 0, 0, 0, 128, (i == 8) ? 1 : 0};
    vecs[9]  = '{4, 0, 0, 0, 4, 137, 0};           // acc 1032 -> 129 + 8
    // timeout window sits here: acc 1095, code clamps to 255
    vecs[10] = '{2, 0, 0, 0, 2, 141, 0};           // acc 1097 -> 137 + 4
    vecs[11] = '{0, 3, 0, 0, -3, 130, 0};          // acc 1094 -> 136 - 6
    for (int i = 12; i <= 19; i++)
      vecs[i] = '{3, 3, 0, 0, 0, 136, (i == 19) ? 1 : 0};
    // enable drop sits here: nothing changes
    vecs[20] = '{2, 0, 0, 0, 2, 141, 0};           // acc 1096 -> 137 + 4
    // reset sits here: acc back to 1024
    vecs[21] = '{2, 0, 0, 0, 2, 132, 0};           // acc 1026 -> 128 + 4

    reset_b = 1'b0;
    en      = 1'b0;
    up      = 1'b0;
    dn      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset dco", int'(dco_code), 128);
    check("reset err", int'($signed(err)), 0);
    check("reset lock", int'(lock), 0);
    check("reset vld", int'(code_vld), 0);
    reset_b = 1'b1;
    en      = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i <= 9; i++) run_vec(i);

    // UP stuck high: one timeout update, then silence until UP falls.
    up = 1'b1;
    count_vld(70, c);
    check("timeout strobes", c, 1);
    check("timeout err", cap_err, 63);
    check("timeout dco", cap_dco, 255);
    up = 1'b0;
    count_vld(10, c);
    check("stuck strobes", c, 0);

    for (int i = 10; i <= 19; i++) run_vec(i);

    // Enable dropped mid-window while locked.
    up = 1'b1;
    count_vld(4, c);
    en = 1'b0;
    count_vld(3, c2);
    up = 1'b0;
    count_vld(6, c3);
    check("en-off strobes", c + c2 + c3, 0);
    check("en-off lock", int'(lock), 0);
    check("en-off dco", int'(dco_code), 136);
    en = 1'b1;
    count_vld(6, c);
    check("en-on strobes", c, 0);
    run_vec(20);

    // Asynchronous reset mid-window, sampled before the next rising edge.
    up = 1'b1;
    count_vld(4, c);
    @(posedge clk);
    #1 reset_b = 1'b0;
    @(negedge clk);
    check("async rst dco", int'(dco_code), 128);
    check("async rst err", int'($signed(err)), 0);
    check("async rst lock", int'(lock), 0);
    check("async rst vld", int'(code_vld), 0);
    up = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    run_vec(21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
